ggt_binary: RTL and testbench

//   Binary (Stein) GCD responder for the ggt start/valid protocol: the block driven by the
//   ggt stimulus benches and the PLL-clocked board top.

---
 rtl/ggt_binary.sv | 121 ++++++++++++
 tb/tb_ggt_binary.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ggt_binary.sv
// Binary (Stein) GCD core with start/valid handshake.
// Optional GGT_CYCLE_COUNT_EN adds a saturating busy-cycle counter port cycles_o.
module ggt_binary #(
  parameter int WIDTH = 16,
  parameter int KW    = 5
) (
  input  logic             clk,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] Zahl1_i,
  input  logic [WIDTH-1:0] Zahl2_i,
  output logic             busy_o,
  output logic             valid_o,
`ifdef GGT_CYCLE_COUNT_EN
  output logic [WIDTH-1:0] ergebnis_o,
  output logic [15:0]      cycles_o
`else
  output logic [WIDTH-1:0] ergebnis_o
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_COMMON = 3'd1;
  localparam logic [2:0] S_ODDA   = 3'd2;
  localparam logic [2:0] S_SUB    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] r;
  logic [KW-1:0]    k;

  logic             a_lt_b;
  logic [WIDTH-1:0] ab_min;
  logic [WIDTH-1:0] ab_diff;

  logic             accept;

  assign accept = (state == S_IDLE) && start_i;

  // One compare feeds both min(a,b) and |a-b|
  assign a_lt_b  = (a < b);
  assign ab_min  = a_lt_b ? a : b;
  assign ab_diff = a_lt_b ? (b - a) : (a - b);

  // Stein FSM: one shift, compare or subtract per cycle
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= S_IDLE;
      a          <= '0;
      b          <= '0;
      r          <= '0;
      k          <= '0;
      busy_o     <= 1'b0;
      valid_o    <= 1'b0;
      ergebnis_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            a       <= Zahl1_i;
            b       <= Zahl2_i;
            k       <= '0;
            busy_o  <= 1'b1;
            valid_o <= 1'b0;
            state   <= S_COMMON;
          end
        end
        S_COMMON: begin
          if (a == '0 || b == '0) begin
            r     <= a | b;
            state <= S_DONE;
          end else if (!a[0] && !b[0]) begin
            a <= a >> 1;
            b <= b >> 1;
            k <= k + 1'b1;
          end else begin
            state <= S_ODDA;
          end
        end
        S_ODDA: begin
          if (!a[0]) a <= a >> 1;
          else state <= S_SUB;
        end
        S_SUB: begin
          if (!b[0]) begin
            b <= b >> 1;
          end else if (a == b) begin
            r     <= a << k;
            state <= S_DONE;
          end else begin
            a <= ab_min;
            b <= ab_diff;
          end
        end
        S_DONE: begin
          ergebnis_o <= r;
          valid_o    <= 1'b1;
          busy_o     <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef GGT_CYCLE_COUNT_EN
  // Busy-cycle counter: cleared on accept, saturating, frozen when idle
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cycles_o <= '0;
    end else if (accept) begin
      cycles_o <= '0;
    end else if (busy_o && cycles_o != 16'hFFFF) begin
      cycles_o <= cycles_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ggt_binary.sv
// Directed self-checking bench for ggt_binary.
// Define GGT_CYCLE_COUNT_EN to also check cycles_o.
module tb_ggt_binary;

  logic        clk = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] Zahl1_i = '0;
  logic [15:0] Zahl2_i = '0;
  logic        busy_o;
  logic        valid_o;
  logic [15:0] ergebnis_o;
`ifdef GGT_CYCLE_COUNT_EN
  logic [15:0] cycles_o;
`endif

  int errors = 0;
  int checks = 0;
  int n;

  always #5 clk = ~clk;

  ggt_binary #(.WIDTH(16), .KW(5)) dut (
    .clk        (clk),
    .rst_n_i    (rst_n_i),
    .start_i    (start_i),
    .Zahl1_i    (Zahl1_i),
    .Zahl2_i    (Zahl2_i),
    .busy_o     (busy_o),
    .valid_o    (valid_o),
`ifdef GGT_CYCLE_COUNT_EN
    .ergebnis_o (ergebnis_o),
    .cycles_o   (cycles_o)
`else
    .ergebnis_o (ergebnis_o)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic go(input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    Zahl1_i = x;
    Zahl2_i = y;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!valid_o && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("lat_bound", 32'(cnt <= 67), 32'd1);
  endtask

  task automatic run(input string tag, input logic [15:0] x,
                     input logic [15:0] y, input logic [15:0] exp);
    go(x, y);
    chk({tag, "_acc_valid"}, 32'(valid_o), 32'd0);
    chk({tag, "_acc_busy"}, 32'(busy_o), 32'd1);
    wait_valid(n);
    chk(tag, 32'(ergebnis_o), 32'(exp));
  endtask

  initial begin
    #12;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_res", 32'(ergebnis_o), 32'd0);
`ifdef GGT_CYCLE_COUNT_EN
    chk("rst_cyc", 32'(cycles_o), 32'd0);
`endif
    @(negedge clk);
    rst_n_i = 1'b1;

    run("g24255_12540", 16'd24255, 16'd12540, 16'd165);
`ifdef GGT_CYCLE_COUNT_EN
    chk("cyc_case1", 32'(cycles_o), 32'(n));
`endif
    @(posedge clk);
    #1;
    chk("hold_valid", 32'(valid_o), 32'd1);
    chk("hold_res", 32'(ergebnis_o), 32'd165);
    chk("hold_busy", 32'(busy_o), 32'd0);
`ifdef GGT_CYCLE_COUNT_EN
    chk("cyc_hold", 32'(cycles_o), 32'(n));
`endif

    run("g48_18", 16'd48, 16'd18, 16'd6);
    run("g1024_4096", 16'd1024, 16'd4096, 16'd1024);
    run("g65535", 16'd65535, 16'd65535, 16'd65535);

    run("g0_7", 16'd0, 16'd7, 16'd7);
    chk("lat_0_7", 32'(n), 32'd2);
    run("g9_0", 16'd9, 16'd0, 16'd9);
    chk("lat_9_0", 32'(n), 32'd2);
    run("g0_0", 16'd0, 16'd0, 16'd0);
    chk("lat_0_0", 32'(n), 32'd2);
`ifdef GGT_CYCLE_COUNT_EN
    chk("cyc_zero", 32'(cycles_o), 32'd2);
`endif

    go(16'd24255, 16'd12540);
    repeat (3) @(posedge clk);
    @(negedge clk);
    Zahl1_i = 16'd5;
    Zahl2_i = 16'd10;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    chk("ign_busy", 32'(busy_o), 32'd1);
    wait_valid(n);
    chk("ign_res", 32'(ergebnis_o), 32'd165);
    run("g5_10", 16'd5, 16'd10, 16'd5);

    go(16'd24255, 16'd12540);
    repeat (4) @(posedge clk);
    #3;
    rst_n_i = 1'b0;
    #1;
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_valid", 32'(valid_o), 32'd0);
    chk("arst_res", 32'(ergebnis_o), 32'd0);
`ifdef GGT_CYCLE_COUNT_EN
    chk("arst_cyc", 32'(cycles_o), 32'd0);
`endif
    @(negedge clk);
    rst_n_i = 1'b1;
    run("g21_14", 16'd21, 16'd14, 16'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
